// File: rtl/csr_wif.sv
// Committer-to-CSR write/trap channel. The committer drives it; the CSR file only listens.
// valid is a single-cycle strobe per committed instruction. There is no ready: the responder always accepts.
// trap=1 with valid turns the beat into a trap entry, and addr/data are then ignored.
interface csr_wif #(
  parameter int XLEN = 32
);
  logic [11:0]     addr;
  logic [XLEN-1:0] data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] cause;
  logic            trap;
  logic            valid;

  modport cmt (output addr, data, pc, cause, trap, valid);
  modport rsp (input addr, data, pc, cause, trap, valid);
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: committed writes, trap entry, MRET, free-running mcycle/minstret,
// and a combinational read port that returns pre-write values.
module csr_file #(
  parameter int          XLEN      = 32,
  parameter int          HART_ID   = 0,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  csr_wif.rsp             wbcsr_wif,
  input  logic            mret_vld,
  input  logic            instret_inc,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic        w_trap;
  logic        w_wr;
  logic        w_mret;
  logic        w_inc;
  logic [63:0] w_mcycle_inc;
  logic [63:0] w_minstret_inc;
  logic [31:0] w_mstatus;

  assign w_trap         = wbcsr_wif.valid & wbcsr_wif.trap;
  assign w_wr           = wbcsr_wif.valid & ~wbcsr_wif.trap;
  assign w_mret         = mret_vld & ~w_trap;
  assign w_inc          = instret_inc & ~w_trap;
  assign w_mcycle_inc   = r_mcycle + 64'd1;
  assign w_minstret_inc = r_minstret + {63'd0, w_inc};
  assign w_mstatus      = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

  // Priority on MIE/MPIE: trap entry, then MRET, then a plain mstatus write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (w_trap) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (w_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr && wbcsr_wif.addr == A_MSTATUS) begin
      r_mie  <= wbcsr_wif.data[3];
      r_mpie <= wbcsr_wif.data[7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtvec    <= {MTVEC_RST[31:2], 2'b00};
      r_mscratch <= 32'd0;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
      r_mtval    <= 32'd0;
    end else if (w_trap) begin
      r_mepc   <= {wbcsr_wif.pc[31:2], 2'b00};
      r_mcause <= wbcsr_wif.cause;
      r_mtval  <= 32'd0;
    end else if (w_wr) begin
      case (wbcsr_wif.addr)
        A_MTVEC:    r_mtvec    <= {wbcsr_wif.data[31:2], 2'b00};
        A_MSCRATCH: r_mscratch <= wbcsr_wif.data;
        A_MEPC:     r_mepc     <= {wbcsr_wif.data[31:2], 2'b00};
        A_MCAUSE:   r_mcause   <= wbcsr_wif.data;
        A_MTVAL:    r_mtval    <= wbcsr_wif.data;
        default:    ;
      endcase
    end
  end

  // Writing one half of a counter replaces that half; the other half never sees the carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      if (w_wr && wbcsr_wif.addr == A_MCYCLE)
        r_mcycle <= {r_mcycle[63:32], wbcsr_wif.data};
      else if (w_wr && wbcsr_wif.addr == A_MCYCLEH)
        r_mcycle <= {wbcsr_wif.data, w_mcycle_inc[31:0]};
      else
        r_mcycle <= w_mcycle_inc;

      if (w_wr && wbcsr_wif.addr == A_MINSTRET)
        r_minstret <= {r_minstret[63:32], wbcsr_wif.data};
      else if (w_wr && wbcsr_wif.addr == A_MINSTRETH)
        r_minstret <= {wbcsr_wif.data, w_minstret_inc[31:0]};
      else
        r_minstret <= w_minstret_inc;
    end
  end

  always_comb begin
    rd_data    = 32'd0;
    rd_illegal = 1'b0;
    case (rd_addr)
      A_MSTATUS:               rd_data = w_mstatus;
      A_MISA:                  rd_data = MISA_VAL;
      A_MTVEC:                 rd_data = r_mtvec;
      A_MSCRATCH:              rd_data = r_mscratch;
      A_MEPC:                  rd_data = r_mepc;
      A_MCAUSE:                rd_data = r_mcause;
      A_MTVAL:                 rd_data = r_mtval;
      A_MCYCLE,   A_CYCLE:     rd_data = r_mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:    rd_data = r_mcycle[63:32];
      A_MINSTRET, A_INSTRET:   rd_data = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: rd_data = r_minstret[63:32];
      A_MHARTID:               rd_data = 32'(HART_ID);
      default:                 rd_illegal = 1'b1;
    endcase
  end

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_mie;
endmodule
